// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses when the PC loads and from which source,
// handshakes with instruction memory and the execute stage, and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             ir_load,
    output logic             exec_start,
    input  logic             exec_done,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOOT   = 3'd1,
        S_FETCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // The reset vector feeds the PC mux directly; it must be word aligned for the +4 path.
    if (FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 65535 || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_param
        $error("pc_sequencer: FETCH_TIMEOUT out of range or RESET_VECTOR misaligned");
    end

    state_t           state_reg;
    state_t           state_next;
    logic             halt_latch_reg;
    logic [15:0]      to_cnt_reg;
    logic [16:0]      to_cnt_inc;
    logic             timeout_hit;
    logic             jump_reg;
    logic             branch_reg;
    logic             exec_start_reg;
    logic [CNT_W-1:0] count_reg;

    assign to_cnt_inc  = {1'b0, to_cnt_reg} + 17'd1;
    assign timeout_hit = (to_cnt_inc == 17'(FETCH_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            halt_latch_reg <= 1'b0;
            to_cnt_reg     <= 16'd0;
            jump_reg       <= 1'b0;
            branch_reg     <= 1'b0;
            exec_start_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            exec_start_reg <= (state_next == S_EXEC) && (state_reg != S_EXEC);

            if ((state_next == S_FETCH) && (state_reg != S_FETCH)) begin
                to_cnt_reg <= 16'd0;
            end else if ((state_reg == S_FETCH) && !imem_ack) begin
                to_cnt_reg <= to_cnt_inc[15:0];
            end

            if ((state_reg == S_EXEC) && exec_done) begin
                jump_reg   <= jump;
                branch_reg <= branch_taken;
            end

            // Clearing on entry to HALTED takes priority over a coincident request.
            if ((state_next == S_HALTED) && (state_reg != S_HALTED)) begin
                halt_latch_reg <= 1'b0;
            end else if (halt_req && (state_reg != S_IDLE) && (state_reg != S_FAULT)) begin
                halt_latch_reg <= 1'b1;
            end

            if (state_reg == S_UPDATE) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b0;
        pc_sel     = 2'b11;
        imem_req   = 1'b0;
        fault      = 1'b0;
        ir_load    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_BOOT;
            end
            S_BOOT: begin
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack & ~imem_err;
                // An ack in the timeout cycle still completes the fetch.
                if (imem_ack) begin
                    state_next = imem_err ? S_FAULT : S_EXEC;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_EXEC: begin
                if (exec_done) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                pc_en = 1'b1;
                if (jump_reg) begin
                    pc_sel = 2'b10;
                end else if (branch_reg) begin
                    pc_sel = 2'b01;
                end else begin
                    pc_sel = 2'b00;
                end
                state_next = (halt_latch_reg || !run) ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (run && !halt_req) state_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign state       = state_reg;
    assign exec_start  = exec_start_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-plus-random bench for pc_sequencer: each instruction is described by its
// fetch/exec wait lengths and redirect flags, and the expected per-cycle outputs follow from those.
module tb_pc_sequencer;

    localparam int CW = 4;
    localparam int TO = 4;

    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_BOOT   = 32'd1;
    localparam logic [31:0] ST_FETCH  = 32'd2;
    localparam logic [31:0] ST_EXEC   = 32'd3;
    localparam logic [31:0] ST_UPDATE = 32'd4;
    localparam logic [31:0] ST_HALTED = 32'd5;
    localparam logic [31:0] ST_FAULT  = 32'd6;

    logic          clk;
    logic          rst;
    logic          run;
    logic          halt_req;
    logic          imem_req;
    logic          imem_ack;
    logic          imem_err;
    logic          ir_load;
    logic          exec_start;
    logic          exec_done;
    logic          branch_taken;
    logic          jump;
    logic          pc_en;
    logic [1:0]    pc_sel;
    logic [2:0]    state;
    logic          fault;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int instr_no = 0;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_1000),
        .FETCH_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt_req    (halt_req),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_err    (imem_err),
        .ir_load     (ir_load),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .branch_taken(branch_taken),
        .jump        (jump),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .state       (state),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pc_en"},    32'(pc_en),      32'd0);
        check({tag, "_pc_sel"},   32'(pc_sel),     32'd3);
        check({tag, "_imem_req"}, 32'(imem_req),   32'd0);
        check({tag, "_ir_load"},  32'(ir_load),    32'd0);
        check({tag, "_exec_st"},  32'(exec_start), 32'd0);
    endtask

    // Called just after rst is released, FSM in IDLE; returns with the FSM in its first FETCH cycle.
    task automatic boot();
        run = 1'b1;
        #1;
        check("boot_idle_state", 32'(state), ST_IDLE);
        check("boot_idle_pc_en", 32'(pc_en), 32'd0);
        next_cycle();
        check("boot_state",    32'(state),    ST_BOOT);
        check("boot_pc_en",    32'(pc_en),    32'd1);
        check("boot_pc_sel",   32'(pc_sel),   32'd3);
        check("boot_imem_req", 32'(imem_req), 32'd0);
        next_cycle();
    endtask

    // One instruction starting in its first FETCH cycle. hlt: 0 none, 1 pulse in first fetch
    // cycle, 2 pulse in first exec cycle.
    task automatic run_instr(input int fw, input int ew, input bit j, input bit b,
                             input int hlt, input bit run_after, output bit halted);
        logic [31:0] exp_sel;
        for (int i = 0; i <= fw; i++) begin
            imem_ack  = (i == fw);
            imem_err  = 1'b0;
            exec_done = 1'b0;
            halt_req  = (hlt == 1) && (i == 0);
            #1;
            check("fetch_state",    32'(state),    ST_FETCH);
            check("fetch_imem_req", 32'(imem_req), 32'd1);
            check("fetch_ir_load",  32'(ir_load),  32'(i == fw));
            check("fetch_pc_en",    32'(pc_en),    32'd0);
            next_cycle();
        end
        for (int i = 0; i <= ew; i++) begin
            imem_ack     = 1'($urandom_range(0, 1));
            exec_done    = (i == ew);
            jump         = (i == ew) ? j : 1'($urandom_range(0, 1));
            branch_taken = (i == ew) ? b : 1'($urandom_range(0, 1));
            halt_req     = (hlt == 2) && (i == 0);
            #1;
            check("exec_state",    32'(state),      ST_EXEC);
            check("exec_start",    32'(exec_start), 32'(i == 0));
            check("exec_ir_load",  32'(ir_load),    32'd0);
            check("exec_imem_req", 32'(imem_req),   32'd0);
            next_cycle();
        end
        imem_ack     = 1'b0;
        exec_done    = 1'b0;
        jump         = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        halt_req     = 1'b0;
        run          = run_after;
        exp_sel      = j ? 32'd2 : (b ? 32'd1 : 32'd0);
        #1;
        check("upd_state",  32'(state),       ST_UPDATE);
        check("upd_pc_en",  32'(pc_en),       32'd1);
        check("upd_pc_sel", 32'(pc_sel),      exp_sel);
        check("upd_count",  32'(instr_count), 32'(exp_count));
        exp_count = (exp_count + 1) % (1 << CW);
        halted    = (hlt != 0) || !run_after;
        next_cycle();
        check("post_count", 32'(instr_count), 32'(exp_count));
        check("post_pc_en", 32'(pc_en),       32'd0);
        check("post_state", 32'(state),       halted ? ST_HALTED : ST_FETCH);
        instr_no++;
        $display("instr %0d: fetch_wait=%0d exec_wait=%0d jump=%0d branch=%0d pc_sel=%0d count=%0d halted=%0d",
                 instr_no, fw, ew, j, b, exp_sel, exp_count, halted);
    endtask

    task automatic random_instrs(input int n);
        bit h;
        for (int k = 0; k < n; k++) begin
            run_instr($urandom_range(0, TO - 1), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b1, h);
        end
    endtask

    initial begin
        bit h;
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
        exec_done = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_state", 32'(state),       ST_IDLE);
        check("rst_fault", 32'(fault),       32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check_idle_outputs("rst");
        run = 1'b1;
        next_cycle();
        check("rst_hold_state", 32'(state), ST_IDLE);
        next_cycle();
        rst = 1'b1;
        boot();

        // Minimum-period instructions: count reaches 4 twelve cycles after BOOT.
        for (int k = 0; k < 4; k++) run_instr(0, 0, 1'b0, 1'b0, 0, 1'b1, h);
        check("boot_count4", 32'(instr_count), 32'd4);

        run_instr(0, 0, 1'b1, 1'b1, 0, 1'b1, h);
        run_instr(1, 2, 1'b0, 1'b1, 0, 1'b1, h);
        run_instr(TO - 1, 0, 1'b0, 1'b0, 0, 1'b1, h);
        random_instrs(8);

        // Halt requested during EXEC: instruction completes, then HALTED, resume without BOOT.
        run_instr(0, 1, 1'b0, 1'b0, 2, 1'b1, h);
        run = 1'b1; halt_req = 1'b0;
        #1;
        check("halted_state", 32'(state), ST_HALTED);
        check_idle_outputs("halted");
        next_cycle();
        check("resume_state", 32'(state), ST_FETCH);
        run_instr(2, 0, 1'b1, 1'b0, 1, 1'b1, h);
        next_cycle();
        check("resume2_state", 32'(state), ST_FETCH);

        // run dropped at UPDATE: stay halted while run=0.
        run_instr(0, 0, 1'b0, 1'b1, 0, 1'b0, h);
        next_cycle();
        check("runlow_state", 32'(state), ST_HALTED);
        run = 1'b1;
        next_cycle();
        check("runhigh_state", 32'(state), ST_FETCH);
        random_instrs(3);

        // Asynchronous reset dropped between edges in EXEC.
        imem_ack = 1'b1;
        #1;
        next_cycle();
        imem_ack = 1'b0;
        check("pre_arst_state", 32'(state), ST_EXEC);
        #3 rst = 1'b0;
        #1;
        check("arst_state", 32'(state),       ST_IDLE);
        check("arst_count", 32'(instr_count), 32'd0);
        check("arst_fault", 32'(fault),       32'd0);
        check_idle_outputs("arst");
        exp_count = 0;
        next_cycle();
        rst = 1'b1;
        boot();

        // Seventeen instructions with a 4-bit counter wrap to 1.
        random_instrs(17);
        check("wrap_count", 32'(instr_count), 32'd1);

        // Fetch error: FAULT on the next cycle, no IR load, sticky despite run/halt.
        imem_ack = 1'b1; imem_err = 1'b1;
        #1;
        check("ferr_ir_load", 32'(ir_load), 32'd0);
        check("ferr_state",   32'(state),   ST_FETCH);
        next_cycle();
        imem_ack = 1'b0; imem_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run = 1'b1; halt_req = 1'(k == 1);
            #1;
            check("ferr_fault_state", 32'(state),    ST_FAULT);
            check("ferr_fault",       32'(fault),    32'd1);
            check("ferr_imem_req",    32'(imem_req), 32'd0);
            check("ferr_pc_en",       32'(pc_en),    32'd0);
            next_cycle();
        end
        halt_req = 1'b0;

        #2 rst = 1'b0;
        #1;
        check("fault_clr", 32'(fault), 32'd0);
        exp_count = 0;
        next_cycle();
        rst = 1'b1;
        boot();

        // Fetch timeout: four FETCH cycles without ack, then FAULT.
        for (int k = 0; k < TO; k++) begin
            imem_ack = 1'b0;
            #1;
            check("to_state",    32'(state),    ST_FETCH);
            check("to_imem_req", 32'(imem_req), 32'd1);
            check("to_ir_load",  32'(ir_load),  32'd0);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            check("to_fault_state", 32'(state), ST_FAULT);
            check("to_fault",       32'(fault), 32'd1);
            next_cycle();
        end
        check("to_count", 32'(instr_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
